pio_clkdiv_bank: RTL

- Bank of NUM_SM independent fractional clock dividers, one per PIO state machine.
- Each channel produces a single-cycle clock-enable pulse whose average period is INT + FRAC/2^FRAC_W system clocks.
- Replaces the single per-machine divider. Adds a parametrised channel count and field widths, glitch-free divisor update, and multi-channel phase-aligned restart.
- Sits between the PIO configuration decode (DIV action) and the state-machine step enables.

---
 rtl/pio_clkdiv_bank_if.sv | 53 +++++
 rtl/pio_clkdiv_bank.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pio_clkdiv_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : pio_clkdiv_bank_if
// Description : Configuration and step-enable bundle for pio_clkdiv_bank.
//               master : configuration decode side (drives cfg_*, en, restart)
//               slave  : divider bank (drives clk_en, pending[, cfg_dout])
//               Signals:
//                 cfg_we   write strobe for divisor register cfg_idx
//                 cfg_idx  channel select (IDX_W bits)
//                 cfg_div  divisor {INT, FRAC}, INT in the MSBs
//                 en       per-channel run enable
//                 restart  per-channel phase restart pulse
//                 clk_en   per-channel registered step pulse
//                 pending  staged divisor awaiting its reload point
//                 cfg_dout divisor readback (only with PIO_CLKDIV_READBACK_EN)
// Revision    : 1.0 - initial release
// ============================================================================
interface pio_clkdiv_bank_if #(
    parameter int NUM_SM = 4,
    parameter int INT_W  = 16,
    parameter int FRAC_W = 8,
    parameter int IDX_W  = 2
);
    logic                    cfg_we;
    logic [IDX_W-1:0]        cfg_idx;
    logic [INT_W+FRAC_W-1:0] cfg_div;
    logic [NUM_SM-1:0]       en;
    logic [NUM_SM-1:0]       restart;
    logic [NUM_SM-1:0]       clk_en;
    logic [NUM_SM-1:0]       pending;
`ifdef PIO_CLKDIV_READBACK_EN
    logic [INT_W+FRAC_W-1:0] cfg_dout;

    modport master (
        output cfg_we, cfg_idx, cfg_div, en, restart,
        input  clk_en, pending, cfg_dout
    );
    modport slave (
        input  cfg_we, cfg_idx, cfg_div, en, restart,
        output clk_en, pending, cfg_dout
    );
`else
    modport master (
        output cfg_we, cfg_idx, cfg_div, en, restart,
        input  clk_en, pending
    );
    modport slave (
        input  cfg_we, cfg_idx, cfg_div, en, restart,
        output clk_en, pending
    );
`endif
endinterface
`default_nettype wire

// File: rtl/pio_clkdiv_bank.sv
`default_nettype none
// ============================================================================
// Module      : pio_clkdiv_bank
// Description : Bank of NUM_SM independent fractional clock dividers. Each
//               channel emits a one-cycle clk_en pulse whose average period is
//               INT + FRAC/2^FRAC_W clocks. Divisor writes to a running channel
//               are staged and take effect at the next reload; restart aligns
//               channel phases.
// Ports       : clk    system clock (rising edge)
//               reset  synchronous, active-low reset
//               bus    pio_clkdiv_bank_if.slave (cfg_we, cfg_idx, cfg_div, en,
//                      restart in; clk_en, pending[, cfg_dout] out)
// Options     : define PIO_CLKDIV_READBACK_EN to add the registered cfg_dout
//               divisor readback port.
// Revision    : 1.0 - initial release
// ============================================================================
module pio_clkdiv_bank #(
    parameter int NUM_SM = 4,
    parameter int INT_W  = 16,
    parameter int FRAC_W = 8,
    parameter int IDX_W  = 2
) (
    input  wire                    clk,
    input  wire                    reset,
    pio_clkdiv_bank_if.slave       bus
);
    localparam int c_div_w = INT_W + FRAC_W;
    localparam int c_cnt_w = INT_W + 1;
    localparam logic [c_div_w-1:0] c_div_one = {INT_W'(1), FRAC_W'(0)};

    logic [NUM_SM-1:0]              clk_en_vec;
    logic [NUM_SM-1:0]              pending_vec;
    logic [NUM_SM-1:0][c_div_w-1:0] rb_val;

    for (genvar i = 0; i < NUM_SM; i++) begin : g_ch
        logic [c_div_w-1:0] div_cur_q, div_cur_d;
        logic [c_div_w-1:0] div_new_q, div_new_d;
        logic [c_cnt_w-1:0] cnt_q, cnt_d;
        logic [FRAC_W-1:0]  acc_q, acc_d;
        logic               pend_q, pend_d;
        logic               clk_en_q, clk_en_d;

        logic               w_wr_hit;
        logic [c_div_w-1:0] w_div_use;
        logic [INT_W-1:0]   w_int;
        logic [c_cnt_w-1:0] w_int_eff;
        logic [FRAC_W-1:0]  w_frac_eff;
        logic [FRAC_W:0]    w_sum;
        logic [c_cnt_w-1:0] w_reload;

        assign w_wr_hit  = bus.cfg_we && (bus.cfg_idx == IDX_W'(i));
        // A reload with a staged divisor already runs on the staged value.
        assign w_div_use = pend_q ? div_new_q : div_cur_q;
        assign w_int     = w_div_use[c_div_w-1:FRAC_W];
        // INT==0 encodes 2^INT_W, and its FRAC field is ignored.
        assign w_int_eff  = (w_int == '0) ? {1'b1, {INT_W{1'b0}}} : {1'b0, w_int};
        assign w_frac_eff = (w_int == '0) ? '0 : w_div_use[FRAC_W-1:0];
        assign w_sum      = {1'b0, acc_q} + {1'b0, w_frac_eff};
        // Accumulator carry stretches this gap by one clock.
        assign w_reload   = w_int_eff - c_cnt_w'(1) + {{INT_W{1'b0}}, w_sum[FRAC_W]};

        always_comb begin
            div_cur_d = div_cur_q;
            div_new_d = div_new_q;
            cnt_d     = cnt_q;
            acc_d     = acc_q;
            pend_d    = pend_q;
            clk_en_d  = 1'b0;
            if (bus.restart[i]) begin
                cnt_d  = '0;
                acc_d  = '0;
                pend_d = 1'b0;
                if (w_wr_hit)
                    div_cur_d = bus.cfg_div;
                else if (pend_q)
                    div_cur_d = div_new_q;
            end else if (!bus.en[i]) begin
                // Idle channel: a write lands directly, no reload to wait for.
                if (w_wr_hit) begin
                    div_cur_d = bus.cfg_div;
                    pend_d    = 1'b0;
                end
            end else begin
                if (cnt_q == '0) begin
                    clk_en_d = 1'b1;
                    acc_d    = w_sum[FRAC_W-1:0];
                    cnt_d    = w_reload;
                    if (pend_q) begin
                        div_cur_d = div_new_q;
                        pend_d    = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - c_cnt_w'(1);
                end
                // Staging is applied last so a write on a reload edge stays
                // pending for the following reload.
                if (w_wr_hit) begin
                    div_new_d = bus.cfg_div;
                    pend_d    = 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                div_cur_q <= c_div_one;
                div_new_q <= c_div_one;
                cnt_q     <= '0;
                acc_q     <= '0;
                pend_q    <= 1'b0;
                clk_en_q  <= 1'b0;
            end else begin
                div_cur_q <= div_cur_d;
                div_new_q <= div_new_d;
                cnt_q     <= cnt_d;
                acc_q     <= acc_d;
                pend_q    <= pend_d;
                clk_en_q  <= clk_en_d;
            end
        end

        assign clk_en_vec[i]  = clk_en_q;
        assign pending_vec[i] = pend_q;
        assign rb_val[i]      = pend_q ? div_new_q : div_cur_q;
    end

    assign bus.clk_en  = clk_en_vec;
    assign bus.pending = pending_vec;

`ifdef PIO_CLKDIV_READBACK_EN
    logic [c_div_w-1:0] cfg_dout_q, cfg_dout_d;

    always_comb begin
        cfg_dout_d = '0;
        for (int k = 0; k < NUM_SM; k++) begin
            if (bus.cfg_idx == IDX_W'(k))
                cfg_dout_d = rb_val[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            cfg_dout_q <= '0;
        else
            cfg_dout_q <= cfg_dout_d;
    end

    assign bus.cfg_dout = cfg_dout_q;
`else
    // Readback values are only consumed by the optional readback mux.
    logic w_rb_unused;
    assign w_rb_unused = ^rb_val;
`endif

endmodule
`default_nettype wire
